// File: rtl/sd_pkg.sv
// Shared constants and FSM encoding for the single-sector byte server.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int TAG_W        = 23;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_WB      = 3'd2,
    ST_FILL    = 3'd3,
    ST_ACCESS  = 3'd4,
    ST_RESPOND = 3'd5,
    ST_HOLD    = 3'd6
  } sd_state_e;

endpackage

// File: rtl/sd_sector_ram.sv
// One-sector byte buffer: single write port, registered read, contents never reset.
module sd_sector_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_byte_server.sv
// Byte-granular read/write front end over a sector block engine, caching one sector
// with write-back on eviction. State is observable as r_state (sd_state_e).
//
// Handshakes: sd_read/sd_write are levels held until the one-cycle sd_ready pulse;
// blk_rd_req/blk_wr_req are levels held until the one-cycle blk_done pulse, with
// blk_rd_valid qualifying each fill byte and blk_wr_next acknowledging each
// write-back byte presented on blk_wr_data.
module sd_byte_server
  import sd_pkg::*;
#(
  parameter int SECTOR_BITS = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sd_read,
  input  logic                    sd_write,
  input  logic [31:0]             sd_addr,
  input  logic [7:0]              sd_write_data,
  output logic [7:0]              sd_read_data,
  output logic                    sd_ready,
  output logic                    blk_rd_req,
  output logic                    blk_wr_req,
  output logic [31-SECTOR_BITS:0] blk_sector,
  input  logic                    blk_rd_valid,
  input  logic [7:0]              blk_rd_data,
  input  logic                    blk_wr_next,
  output logic [7:0]              blk_wr_data,
  input  logic                    blk_done,
  input  logic                    blk_err
);

  localparam int TW = 32 - SECTOR_BITS;
  localparam logic [SECTOR_BITS-1:0] OFF_ONE = 1;

  sd_state_e              r_state;
  sd_state_e              w_next;
  logic [31:0]            r_addr;
  logic [7:0]             r_wdata;
  logic                   r_op_wr;
  logic [TW-1:0]          r_tag;
  logic                   r_valid;
  logic                   r_dirty;
  logic [SECTOR_BITS-1:0] r_off;
  logic                   r_fill_full;
  logic                   r_err;
  logic [7:0]             r_last;
  logic                   r_hold;

  logic                   w_hit;
  logic [TW-1:0]          w_req_tag;
  logic [SECTOR_BITS-1:0] w_req_off;
  logic [SECTOR_BITS-1:0] w_off_inc;
  logic                   w_ram_we;
  logic [SECTOR_BITS-1:0] w_ram_waddr;
  logic [7:0]             w_ram_wdata;
  logic [SECTOR_BITS-1:0] w_ram_raddr;
  logic [7:0]             w_ram_q;
  logic [7:0]             w_resp_data;

  assign w_req_tag = r_addr[31:SECTOR_BITS];
  assign w_req_off = r_addr[SECTOR_BITS-1:0];
  assign w_hit     = r_valid && (r_tag == w_req_tag);
  assign w_off_inc = r_off + OFF_ONE;

  sd_sector_ram #(.ADDR_W(SECTOR_BITS)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_off;
    w_ram_wdata = blk_rd_data;
    w_ram_raddr = r_off;
    case (r_state)
      ST_IDLE: begin
        if (sd_read || sd_write) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        // Prefetch byte 0 so it is already on blk_wr_data in the first WB cycle.
        w_ram_raddr = '0;
        if (w_hit)        w_next = ST_ACCESS;
        else if (r_dirty) w_next = ST_WB;
        else              w_next = ST_FILL;
      end
      ST_WB: begin
        w_ram_raddr = blk_wr_next ? w_off_inc : r_off;
        if (blk_done) w_next = blk_err ? ST_RESPOND : ST_FILL;
      end
      ST_FILL: begin
        w_ram_we = blk_rd_valid && !r_fill_full;
        if (blk_done) w_next = blk_err ? ST_RESPOND : ST_ACCESS;
      end
      ST_ACCESS: begin
        w_ram_raddr = w_req_off;
        w_ram_waddr = w_req_off;
        w_ram_wdata = r_wdata;
        w_ram_we    = r_op_wr;
        w_next      = ST_RESPOND;
      end
      ST_RESPOND: w_next = ST_HOLD;
      ST_HOLD: begin
        if (r_hold) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_wr     <= 1'b0;
      r_tag       <= '0;
      r_valid     <= 1'b0;
      r_dirty     <= 1'b0;
      r_off       <= '0;
      r_fill_full <= 1'b0;
      r_err       <= 1'b0;
      r_last      <= '0;
      r_hold      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sd_read || sd_write) begin
            r_addr      <= sd_addr;
            r_wdata     <= sd_write_data;
            r_op_wr     <= sd_write && !sd_read;
            r_err       <= 1'b0;
            r_off       <= '0;
            r_fill_full <= 1'b0;
          end
        end
        ST_WB: begin
          if (blk_done) begin
            r_off       <= '0;
            r_fill_full <= 1'b0;
            r_dirty     <= 1'b0;
            if (blk_err) begin
              r_valid <= 1'b0;
              r_err   <= 1'b1;
            end
          end else if (blk_wr_next) begin
            r_off <= w_off_inc;
          end
        end
        ST_FILL: begin
          // Bytes past the end of the sector are dropped until blk_done.
          if (blk_rd_valid && !r_fill_full) begin
            r_off <= w_off_inc;
            if (r_off == '1) r_fill_full <= 1'b1;
          end
          if (blk_done) begin
            r_dirty <= 1'b0;
            if (blk_err) begin
              r_valid <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_tag   <= w_req_tag;
              r_valid <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (r_op_wr) r_dirty <= 1'b1;
        end
        ST_RESPOND: begin
          r_hold <= 1'b0;
          if (!r_op_wr) r_last <= w_resp_data;
        end
        ST_HOLD: r_hold <= 1'b1;
        default: ;
      endcase
    end
  end

  // Writes answer with the most recent read value; failed transfers answer 8'hFF.
  assign w_resp_data  = r_err ? 8'hFF : (r_op_wr ? r_last : w_ram_q);
  assign sd_ready     = (r_state == ST_RESPOND);
  assign sd_read_data = sd_ready ? w_resp_data : 8'h00;
  assign blk_rd_req   = (r_state == ST_FILL);
  assign blk_wr_req   = (r_state == ST_WB);
  assign blk_sector   = blk_wr_req ? r_tag : w_req_tag;
  assign blk_wr_data  = blk_wr_req ? w_ram_q : 8'h00;

endmodule

// File: tb/tb_sd_byte_server.sv
// Directed bench for sd_byte_server with a behavioural block engine.
module tb_sd_byte_server;
  import sd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sd_read;
  logic        sd_write;
  logic [31:0] sd_addr;
  logic [7:0]  sd_write_data;
  logic [7:0]  sd_read_data;
  logic        sd_ready;
  logic        blk_rd_req;
  logic        blk_wr_req;
  logic [22:0] blk_sector;
  logic        blk_rd_valid;
  logic [7:0]  blk_rd_data;
  logic        blk_wr_next;
  logic [7:0]  blk_wr_data;
  logic        blk_done;
  logic        blk_err;

  int total = 0;
  int bad   = 0;

  // Per-transaction observations
  int          lat;
  logic [7:0]  got_data;
  bit          fill_seen, wb_seen, fill_after_wb, both_seen;
  logic [31:0] fill_sector, wb_sector;
  int          fill_cnt, wb_cnt, extra_ready;
  logic [7:0]  wb_mem [512];

  sd_byte_server #(.SECTOR_BITS(9)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sd_read       (sd_read),
    .sd_write      (sd_write),
    .sd_addr       (sd_addr),
    .sd_write_data (sd_write_data),
    .sd_read_data  (sd_read_data),
    .sd_ready      (sd_ready),
    .blk_rd_req    (blk_rd_req),
    .blk_wr_req    (blk_wr_req),
    .blk_sector    (blk_sector),
    .blk_rd_valid  (blk_rd_valid),
    .blk_rd_data   (blk_rd_data),
    .blk_wr_next   (blk_wr_next),
    .blk_wr_data   (blk_wr_data),
    .blk_done      (blk_done),
    .blk_err       (blk_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic engine_idle();
    blk_rd_valid = 1'b0;
    blk_rd_data  = 8'h00;
    blk_wr_next  = 1'b0;
    blk_done     = 1'b0;
    blk_err      = 1'b0;
  endtask

  // Driver: issue one request, serve the block engine, record what happened.
  // Fill byte i is i[7:0]^pat for i<512 and 8'hEE for overflow bytes.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [7:0] wd, input logic ferr, input logic [7:0] pat,
                         input int flen, input int hold_n);
    int  cyc;
    bit  done;
    lat = -1; got_data = 8'hxx;
    fill_seen = 0; wb_seen = 0; fill_after_wb = 0;
    fill_sector = '1; wb_sector = '1;
    fill_cnt = 0; wb_cnt = 0; extra_ready = 0;
    sd_read = rd; sd_write = wr; sd_addr = addr; sd_write_data = wd;
    done = 0; cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      engine_idle();
      if (blk_rd_req && blk_wr_req) both_seen = 1;
      if (sd_ready) begin
        lat = cyc;
        got_data = sd_read_data;
        done = 1;
        if (hold_n == 0) begin
          sd_read = 1'b0;
          sd_write = 1'b0;
        end
      end else if (blk_rd_req) begin
        if (!fill_seen) begin
          fill_seen = 1;
          fill_sector = 32'(blk_sector);
          fill_after_wb = wb_seen;
        end
        if (fill_cnt < flen) begin
          blk_rd_valid = 1'b1;
          blk_rd_data  = (fill_cnt < 512) ? (fill_cnt[7:0] ^ pat) : 8'hEE;
          fill_cnt++;
        end else if (fill_cnt == flen) begin
          blk_done = 1'b1;
          blk_err  = ferr;
          fill_cnt++;
        end
      end else if (blk_wr_req) begin
        if (!wb_seen) begin
          wb_seen = 1;
          wb_sector = 32'(blk_sector);
        end
        if (wb_cnt < 512) begin
          wb_mem[wb_cnt] = blk_wr_data;
          blk_wr_next = 1'b1;
          wb_cnt++;
        end else if (wb_cnt == 512) begin
          blk_done = 1'b1;
          wb_cnt++;
        end
      end
    end
    check("txn_timeout", 32'(done), 32'd1);
    for (int k = 0; k < hold_n + 9; k++) begin
      @(negedge clk);
      if (sd_ready) extra_ready++;
      if (k == hold_n) begin
        sd_read = 1'b0;
        sd_write = 1'b0;
      end
    end
    check("no_extra_ready", 32'(extra_ready), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    sd_read = 1'b0; sd_write = 1'b0; sd_addr = '0; sd_write_data = '0;
    both_seen = 0;
    engine_idle();
    repeat (3) @(negedge clk);

    check("rst_sd_ready",   32'(sd_ready),     32'd0);
    check("rst_blk_rd_req", 32'(blk_rd_req),   32'd0);
    check("rst_blk_wr_req", 32'(blk_wr_req),   32'd0);
    check("rst_read_data",  32'(sd_read_data), 32'h00);
    check("rst_wr_data",    32'(blk_wr_data),  32'h00);
    check("rst_state",      32'(dut.r_state),  32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss: fill sector 5, byte 0x05 = 0x05
    run_txn(1, 0, 32'h0000_0A05, 8'h00, 0, 8'h00, 512, 0);
    check("miss_fill_seen",   32'(fill_seen), 32'd1);
    check("miss_fill_sector", fill_sector,    32'd5);
    check("miss_no_wb",       32'(wb_seen),   32'd0);
    check("miss_data",        32'(got_data),  32'h05);

    // Hit read: no engine traffic, three-cycle latency
    run_txn(1, 0, 32'h0000_0A06, 8'h00, 0, 8'h00, 512, 0);
    check("hit_no_fill", 32'(fill_seen), 32'd0);
    check("hit_no_wb",   32'(wb_seen),   32'd0);
    check("hit_latency", 32'(lat),       32'd3);
    check("hit_data",    32'(got_data),  32'h06);

    // Hit write: returns the last read value
    run_txn(0, 1, 32'h0000_0A10, 8'hA7, 0, 8'h00, 512, 0);
    check("wr_no_fill", 32'(fill_seen), 32'd0);
    check("wr_latency", 32'(lat),       32'd3);
    check("wr_data",    32'(got_data),  32'h06);

    // Dirty eviction; fill of sector 6 carries two overflow bytes that must be dropped
    run_txn(1, 0, 32'h0000_0C00, 8'h00, 0, 8'h00, 514, 0);
    check("evict_wb_seen",    32'(wb_seen),       32'd1);
    check("evict_wb_sector",  wb_sector,          32'd5);
    check("evict_wb_byte0",   32'(wb_mem[0]),     32'h00);
    check("evict_wb_byte10",  32'(wb_mem[16]),    32'hA7);
    check("evict_wb_byte11",  32'(wb_mem[17]),    32'h11);
    check("evict_wb_byte1ff", 32'(wb_mem[511]),   32'hFF);
    check("evict_fill_order", 32'(fill_after_wb), 32'd1);
    check("evict_fill_sect",  fill_sector,        32'd6);
    check("evict_data_ovfl",  32'(got_data),      32'h00);

    run_txn(1, 0, 32'h0000_0C01, 8'h00, 0, 8'h00, 512, 0);
    check("s6_hit_no_fill", 32'(fill_seen), 32'd0);
    check("s6_hit_data",    32'(got_data),  32'h01);

    // Failed fill of sector 7
    run_txn(1, 0, 32'h0000_0E00, 8'h00, 1, 8'h00, 512, 0);
    check("err_fill_sector", fill_sector,          32'd7);
    check("err_data",        32'(got_data),        32'hFF);
    check("err_valid",       32'(dut.r_valid),     32'd0);

    run_txn(1, 0, 32'h0000_0E03, 8'h00, 0, 8'h5A, 512, 0);
    check("refill_seen", 32'(fill_seen), 32'd1);
    check("refill_data", 32'(got_data),  32'h59);

    // Reset in the middle of a fill of sector 8
    sd_read = 1'b1; sd_write = 1'b0; sd_addr = 32'h0000_1000;
    fill_cnt = 0; cyc = 0;
    while (fill_cnt < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      engine_idle();
      if (blk_rd_req) begin
        blk_rd_valid = 1'b1;
        blk_rd_data  = fill_cnt[7:0] ^ 8'h77;
        fill_cnt++;
      end
    end
    check("midfill_reached", 32'(fill_cnt), 32'd100);
    @(negedge clk);
    engine_idle();
    check("midfill_active", 32'(blk_rd_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_req",    32'(blk_rd_req),   32'd0);
    check("midrst_wr_req",    32'(blk_wr_req),   32'd0);
    check("midrst_ready",     32'(sd_ready),     32'd0);
    check("midrst_read_data", 32'(sd_read_data), 32'h00);
    check("midrst_state",     32'(dut.r_state),  32'(ST_IDLE));
    sd_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 0, 32'h0000_1002, 8'h00, 0, 8'h33, 512, 0);
    check("restart_fill_sect", fill_sector,       32'd8);
    check("restart_data",      32'(got_data),     32'h31);

    // Read and write together: read wins; request kept high through the hold-off
    run_txn(1, 1, 32'h0000_1000, 8'h99, 0, 8'h00, 512, 2);
    check("both_no_fill", 32'(fill_seen), 32'd0);
    check("both_data",    32'(got_data),  32'h33);

    run_txn(1, 0, 32'h0000_1000, 8'h00, 0, 8'h00, 512, 0);
    check("both_not_written", 32'(got_data), 32'h33);

    // Still clean: moving to sector 9 must not write back
    run_txn(1, 0, 32'h0000_1200, 8'h00, 0, 8'h00, 512, 0);
    check("clean_no_wb",     32'(wb_seen),   32'd0);
    check("clean_fill_sect", fill_sector,    32'd9);
    check("clean_data",      32'(got_data),  32'h00);

    check("never_both_reqs", 32'(both_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
